// File: rtl/neural_soc_pio_pkg.sv
// Shared constants for the neural SoC parallel input port: register
// addresses and edge-capture mode encodings.
package neural_soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/neural_soc_pio_sync.sv
// Two-flop synchroniser bringing an asynchronous input bus into the clk
// domain; both stages clear on the asynchronous active-high reset.
module neural_soc_pio_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/neural_soc_pio_in.sv
// Avalon-MM input port with sticky per-bit edge capture and a maskable level
// interrupt. Define NEURAL_SOC_PIO_IN_SYNC_EN to add a 2-flop input synchroniser.
module neural_soc_pio_in #(
    parameter int WIDTH     = 32,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    import neural_soc_pio_pkg::*;

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_next;
    logic             mask_we;

`ifdef NEURAL_SOC_PIO_IN_SYNC_EN
    neural_soc_pio_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (data_in)
    );
`else
    assign data_in = in_port;
`endif

    // Bits of writedata above WIDTH are never stored.
    if (WIDTH < 32) begin : g_wdata_hi
        logic wdata_hi_unused;
        assign wdata_hi_unused = ^writedata[31:WIDTH];
    end

    always_comb begin
        edge_hit = data_in & ~prev;
        case (EDGE_TYPE)
            EDGE_FALL: edge_hit = ~data_in & prev;
            EDGE_ANY:  edge_hit = data_in ^ prev;
            default:   edge_hit = data_in & ~prev;
        endcase
    end

    assign mask_we = write && (address == ADDR_MASK);

    always_comb begin
        clr = '0;
        if (write && (address == ADDR_EDGE)) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next[WIDTH-1:0] = data_in;
            ADDR_MASK: rd_next[WIDTH-1:0] = mask;
            ADDR_EDGE: rd_next[WIDTH-1:0] = capture;
            default:   rd_next = '0;
        endcase
    end

    // The edge term is OR-ed in after the clear so a new edge beats a
    // same-cycle software clear and is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            capture  <= '0;
            mask     <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            prev     <= data_in;
            capture  <= (capture & ~clr) | edge_hit;
            if (mask_we) begin
                mask <= writedata[WIDTH-1:0];
            end
            irq      <= |(capture & mask);
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_neural_soc_pio_in.sv
// Directed scoreboard bench for neural_soc_pio_in: one rising-edge and one
// any-edge instance (WIDTH=8) share the bus and the input port.
module tb_neural_soc_pio_in;

`ifdef NEURAL_SOC_PIO_IN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata_a;
    logic [31:0] readdata_b;
    logic        irq_a;
    logic        irq_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    string       tag_q[$];

    neural_soc_pio_in #(
        .WIDTH     (8),
        .EDGE_TYPE (0)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata_a),
        .in_port   (in_port),
        .irq       (irq_a)
    );

    neural_soc_pio_in #(
        .WIDTH     (8),
        .EDGE_TYPE (2)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata_b),
        .in_port   (in_port),
        .irq       (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkIrq(input string tag, input logic exp_a, input logic exp_b);
        checkOutput({tag, "_irq_a"}, {31'b0, irq_a}, {31'b0, exp_a});
        checkOutput({tag, "_irq_b"}, {31'b0, irq_b}, {31'b0, exp_b});
    endtask

    task automatic applyStimulus(input logic [7:0] value, input int cycles);
        in_port = value;
        repeat (cycles) tick();
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        write     = 1'b1;
        writedata = d;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    // Expected read data is queued with the request and retired when the
    // registered readdata appears one cycle later.
    task automatic readReg(input logic [1:0] a, input logic [31:0] exp_a,
                           input logic [31:0] exp_b, input string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        string       t;
        address = a;
        write   = 1'b0;
        exp_a_q.push_back(exp_a);
        exp_b_q.push_back(exp_b);
        tag_q.push_back(tag);
        tick();
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        t  = tag_q.pop_front();
        checkOutput({t, "_a"}, readdata_a, ea);
        checkOutput({t, "_b"}, readdata_b, eb);
    endtask

    initial begin
        reset     = 1'b1;
        address   = '0;
        write     = 1'b0;
        writedata = '0;
        in_port   = '0;
        $display("[TB] start, sync latency %0d", SYNC_LAT);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rd_a", readdata_a, 32'h0);
        checkOutput("reset_rd_b", readdata_b, 32'h0);
        checkIrq("reset", 1'b0, 1'b0);
        #2 reset = 1'b0;

        readReg(2'd0, 32'h0, 32'h0, "init_data");
        readReg(2'd1, 32'h0, 32'h0, "init_rsvd");
        readReg(2'd2, 32'h0, 32'h0, "init_mask");
        readReg(2'd3, 32'h0, 32'h0, "init_edge");
        checkIrq("init", 1'b0, 1'b0);

        writeReg(2'd1, 32'hFFFF_FFFF);
        writeReg(2'd0, 32'hFFFF_FFFF);
        readReg(2'd1, 32'h0, 32'h0, "rsvd_wr_ignored");
        readReg(2'd0, 32'h0, 32'h0, "data_wr_ignored");

        // Basic capture and DATA read-back.
        applyStimulus(8'h05, 4);
        readReg(2'd3, 32'h05, 32'h05, "cap_05");
        readReg(2'd0, 32'h05, 32'h05, "data_05");
        readReg(2'd3, 32'h05, 32'h05, "cap_sticky");
        checkIrq("masked_off", 1'b0, 1'b0);

        // Interrupt latency on a bit 2 rising edge.
        applyStimulus(8'h01, 4);
        writeReg(2'd3, 32'h0000_00FF);
        writeReg(2'd2, 32'h0000_0004);
        tick();
        checkIrq("mask_clean", 1'b0, 1'b0);
        in_port = 8'h05;
        for (int j = 1; j <= SYNC_LAT + 2; j++) begin
            tick();
            checkIrq($sformatf("irq_lat%0d", j), (j == SYNC_LAT + 2), (j == SYNC_LAT + 2));
        end
        writeReg(2'd3, 32'h0000_0004);
        checkIrq("clr_hold", 1'b1, 1'b1);
        tick();
        checkIrq("clr_drop", 1'b0, 1'b0);

        // Rising edge on bit 0 lands in capture on the same edge as a clear.
        applyStimulus(8'h04, 4);
        writeReg(2'd3, 32'h0000_00FF);
        applyStimulus(8'h05, SYNC_LAT);
        writeReg(2'd3, 32'h0000_0001);
        readReg(2'd3, 32'h01, 32'h01, "set_wins");

        // Mask changes drive irq one cycle after they take effect.
        writeReg(2'd2, 32'h0000_0001);
        checkIrq("mask_on_hold", 1'b0, 1'b0);
        tick();
        checkIrq("mask_on_rise", 1'b1, 1'b1);
        writeReg(2'd2, 32'h0000_0000);
        checkIrq("mask_off_hold", 1'b1, 1'b1);
        tick();
        checkIrq("mask_off_drop", 1'b0, 1'b0);

        // Any-edge instance sees both directions; rising-only sees 0xFA.
        applyStimulus(8'hFF, 4);
        applyStimulus(8'h00, 4);
        readReg(2'd3, 32'hFB, 32'hFF, "cap_ff_00");
        readReg(2'd0, 32'h00, 32'h00, "data_00");
        writeReg(2'd3, 32'h0000_00FF);
        writeReg(2'd2, 32'hFFFF_FFFF);
        readReg(2'd2, 32'hFF, 32'hFF, "mask_width");
        readReg(2'd3, 32'h00, 32'h00, "cap_cleared");
        checkIrq("cleared_full_mask", 1'b0, 1'b0);

        // Asynchronous reset in the middle of activity.
        applyStimulus(8'h3C, 4);
        readReg(2'd3, 32'h3C, 32'h3C, "cap_3c");
        tick();
        checkIrq("pre_reset", 1'b1, 1'b1);
        #2;
        reset   = 1'b1;
        in_port = 8'h00;
        #1;
        checkOutput("async_rd_a", readdata_a, 32'h0);
        checkOutput("async_rd_b", readdata_b, 32'h0);
        checkIrq("async", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        readReg(2'd3, 32'h0, 32'h0, "post_rst_edge");
        readReg(2'd2, 32'h0, 32'h0, "post_rst_mask");
        checkIrq("post_rst", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
